// File: rtl/zero_run_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : zero_run_emitter
//  Purpose  : Accepts a leading-zero run length over a valid/ready handshake
//             and streams the canonical IN_W-bit word (run zeros, a single
//             one, then zero fill) MSB first over a valid/ready bit stream.
//             Counts above IN_W are clamped and flagged with a one-cycle err.
//  Revision : 1.0  initial release
// ============================================================================
module zero_run_emitter #(
  parameter int IN_W  = 8,                    // word width, IN_W >= 2
  parameter int CNT_W = $clog2(IN_W + 1)      // holds 0..IN_W inclusive
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  input  logic [CNT_W-1:0] cnt,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_data,
  output logic             bit_last,
  output logic             err
);

  // Position counter only needs to reach IN_W-1.
  localparam int P_W = $clog2(IN_W);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] MAX_RUN  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] ONE_EXT  = CNT_W'(1);
  localparam logic [P_W-1:0]   ONE_P    = P_W'(1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;

  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_nxt;
  logic [P_W-1:0]   p;
  logic [P_W-1:0]   p_nxt;

  logic             cnt_ready_nxt;
  logic             bit_valid_nxt;
  logic             bit_data_nxt;
  logic             bit_last_nxt;
  logic             err_nxt;

  logic [CNT_W-1:0] p_ext;
  logic [CNT_W-1:0] p_inc_ext;
  logic [CNT_W-1:0] cnt_clamped;
  logic             cnt_over;
  logic             accept;
  logic             beat;

  // Widen the position counter so it can be compared against the run length.
  generate
    if (CNT_W > P_W) begin : g_ext_pad
      assign p_ext = {{(CNT_W - P_W){1'b0}}, p};
    end else begin : g_ext_same
      assign p_ext = p[CNT_W-1:0];
    end
  endgenerate

  assign p_inc_ext   = p_ext + ONE_EXT;
  assign cnt_over    = (cnt > MAX_RUN);
  assign cnt_clamped = cnt_over ? MAX_RUN : cnt;

  // cnt_ready is only high in IDLE and bit_valid only in RUN, so these
  // handshakes are already qualified by state.
  assign accept = cnt_valid & cnt_ready;
  assign beat   = bit_valid & bit_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a count handshake starts a word, the last beat ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (beat && bit_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath logic: computes the next value of every registered output
  // so the ports are driven straight from flops.
  always_comb begin
    run_nxt       = run;
    p_nxt         = p;
    cnt_ready_nxt = cnt_ready;
    bit_valid_nxt = bit_valid;
    bit_data_nxt  = bit_data;
    bit_last_nxt  = bit_last;
    err_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_ready_nxt = 1'b1;
        bit_valid_nxt = 1'b0;
        bit_data_nxt  = 1'b0;
        bit_last_nxt  = 1'b0;
        if (accept) begin
          // Present position 0 on the very next cycle.
          run_nxt       = cnt_clamped;
          p_nxt         = '0;
          cnt_ready_nxt = 1'b0;
          bit_valid_nxt = 1'b1;
          bit_data_nxt  = (cnt_clamped == '0);
          bit_last_nxt  = (LAST_POS == '0);
          err_nxt       = cnt_over;
        end
      end
      S_RUN: begin
        // Without a beat everything holds, which covers stalls of any length.
        if (beat) begin
          if (bit_last) begin
            p_nxt         = '0;
            cnt_ready_nxt = 1'b1;
            bit_valid_nxt = 1'b0;
            bit_data_nxt  = 1'b0;
            bit_last_nxt  = 1'b0;
          end else begin
            // A clamped run of IN_W never matches, giving an all-zero word.
            p_nxt        = p + ONE_P;
            bit_data_nxt = (p_inc_ext == run);
            bit_last_nxt = (p_inc_ext == LAST_POS);
          end
        end
      end
      default: begin
        p_nxt         = '0;
        cnt_ready_nxt = 1'b1;
        bit_valid_nxt = 1'b0;
        bit_data_nxt  = 1'b0;
        bit_last_nxt  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any word in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= '0;
      p         <= '0;
      cnt_ready <= 1'b1;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
      bit_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      run       <= run_nxt;
      p         <= p_nxt;
      cnt_ready <= cnt_ready_nxt;
      bit_valid <= bit_valid_nxt;
      bit_data  <= bit_data_nxt;
      bit_last  <= bit_last_nxt;
      err       <= err_nxt;
    end
  end

  // The two handshake sides are never open at the same time.
  a_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(cnt_ready && bit_valid));

  // A stalled beat keeps its payload until it is taken.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bit_valid && !bit_ready) |=> (bit_valid && $stable(bit_data) && $stable(bit_last)));

endmodule
`default_nettype wire

// File: tb/tb_zero_run_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zero_run_emitter
//  Purpose  : Self-checking bench for zero_run_emitter: vector table, directed
//             multi-cycle corner cases and randomized words against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zero_run_emitter;

  localparam int IN_W  = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cnt_valid = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic             bit_ready = 1'b0;
  logic             cnt_ready;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_last;
  logic             err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         c;
    logic [7:0] word;
    logic       e;
  } vec_t;

  vec_t vecs[8];

  zero_run_emitter #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt       (cnt),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_data  (bit_data),
    .bit_last  (bit_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference word: a marker one shifted right by the run length, MSB first.
  function automatic logic [7:0] ref_word(input int c);
    logic [7:0] marker;
    marker = 8'h80;
    return (c >= IN_W) ? 8'h00 : (marker >> c);
  endfunction

  // Leading-zero count of a collected word (IN_W for all zeros).
  function automatic int lzc(input logic [7:0] w);
    int n;
    n = 0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (w[i]) return n;
      n++;
    end
    return n;
  endfunction

  // Issue one count and collect its word. Called one step after a rising
  // edge with the block idle. pct is the per-cycle probability of bit_ready,
  // stall_at forces a 5-cycle stall on that bit index, keep_valid keeps
  // cnt_valid high (with next_c on cnt) for a back-to-back follow-up.
  task automatic do_word(input int c, input logic [7:0] exp_w, input logic exp_e,
                         input int pct, input int stall_at,
                         input bit keep_valid, input int next_c);
    logic [7:0] got;
    int         idx;
    int         cyc;
    int         stall_n;
    logic       rdy;
    got     = '0;
    idx     = 0;
    cyc     = 0;
    stall_n = 0;
    cnt_valid = 1'b1;
    cnt       = CNT_W'(c);
    chkb("cnt_ready_idle", cnt_ready, 1'b1);
    @(posedge clk); #1;
    if (keep_valid) cnt = CNT_W'(next_c);
    else cnt_valid = 1'b0;
    chkb("first_bit_latency", bit_valid, 1'b1);
    chkb("err_pulse", err, exp_e);
    while (idx < IN_W && cyc < 300) begin
      rdy = ($urandom_range(0, 99) < pct);
      if (idx == stall_at && stall_n < 5) begin
        rdy = 1'b0;
        stall_n++;
      end
      bit_ready = rdy;
      chkb("valid_held", bit_valid, 1'b1);
      chkb("bit_data", bit_data, exp_w[IN_W-1-idx]);
      chkb("bit_last", bit_last, (idx == IN_W - 1));
      if (cyc > 0) chkb("err_quiet", err, 1'b0);
      if (rdy) begin
        got[IN_W-1-idx] = bit_data;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    // Downstream readiness must not matter while idle.
    bit_ready = 1'($urandom_range(0, 1));
    chki("word_complete", idx, IN_W);
    chkb("idle_valid", bit_valid, 1'b0);
    chkb("idle_ready", cnt_ready, 1'b1);
    chki("loopback_lzc", lzc(got), (c > IN_W) ? IN_W : c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{c: 3,  word: 8'h10, e: 1'b0};
    vecs[1] = '{c: 0,  word: 8'h80, e: 1'b0};
    vecs[2] = '{c: 7,  word: 8'h01, e: 1'b0};
    vecs[3] = '{c: 8,  word: 8'h00, e: 1'b0};
    vecs[4] = '{c: 11, word: 8'h00, e: 1'b1};
    vecs[5] = '{c: 15, word: 8'h00, e: 1'b1};
    vecs[6] = '{c: 1,  word: 8'h40, e: 1'b0};
    vecs[7] = '{c: 5,  word: 8'h04, e: 1'b0};

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chkb("reset_cnt_ready", cnt_ready, 1'b1);
    chkb("reset_bit_valid", bit_valid, 1'b0);
    chkb("reset_bit_data", bit_data, 1'b0);
    chkb("reset_bit_last", bit_last, 1'b0);
    chkb("reset_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, full-rate downstream.
    for (int i = 0; i < 8; i++) begin
      do_word(vecs[i].c, vecs[i].word, vecs[i].e, 100, -1, 1'b0, 0);
    end

    // Marker bit stalled for 5 cycles under random back-pressure.
    do_word(2, 8'h20, 1'b0, 60, 2, 1'b0, 0);

    // Back-to-back counts with cnt_valid held high throughout.
    do_word(1, 8'h40, 1'b0, 100, -1, 1'b1, 5);
    do_word(5, 8'h04, 1'b0, 100, -1, 1'b0, 0);

    // Reset in the middle of a cnt=6 word, after bits 0..4 were taken.
    cnt_valid = 1'b1;
    cnt       = CNT_W'(6);
    @(posedge clk); #1;
    cnt_valid = 1'b0;
    bit_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chkb("pre_reset_valid", bit_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("async_abort_valid", bit_valid, 1'b0);
    chkb("async_abort_ready", cnt_ready, 1'b1);
    chkb("async_abort_last", bit_last, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("post_reset_ready", cnt_ready, 1'b1);
    chkb("post_reset_valid", bit_valid, 1'b0);
    bit_ready = 1'b0;
    do_word(6, 8'h02, 1'b0, 100, -1, 1'b0, 0);

    // Loopback sweep of every legal count against the model.
    for (int c = 0; c <= IN_W; c++) begin
      do_word(c, ref_word(c), 1'b0, 100, -1, 1'b0, 0);
    end

    // Randomized counts (including out-of-range) and back-pressure.
    for (int n = 0; n < 25; n++) begin
      int c;
      int pct;
      c   = int'($urandom_range(0, 15));
      pct = int'($urandom_range(25, 100));
      do_word(c, ref_word(c), (c > IN_W), pct, -1, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
